controller_writeback: RTL
=========================

CONTROLLER_WRITEBACK -- requirements
Module: controller_writeback
Interface
REQ-001 Parameters (name, default, meaning): ddr_addr_width 32 DDR byte address; buffer_addr_width 16 buffer word address; ddr_data_width 512 beat width; ddr_block_size_width 8 beat-count width; buffer_id_width 3 source select.
REQ-002 Ports (name direction width meaning): clk in 1 sole clock; n_reset in 1 asynchronous active-low reset.
REQ-003 start in 1 one-cycle command strobe; done out 1 one-cycle completion pulse; error out 1 one-cycle pulse with done on invalid buffer_id.
REQ-004 buffer_id in buffer_id_width source buffer (0 INST, 1 BIAS, 2 TAIL, 3 RANK); ddr_base_addr in ddr_addr_width; ddr_block_size in ddr_block_size_width beats.
REQ-005 buffer_addr out buffer_addr_width; buffer_inst_rd_en, buffer_bias_rd_en, buffer_tail_rd_en, buffer_rank_rd_en out 1 each; buffer_rd_data in ddr_data_width, valid exactly 1 cycle after a read enable.
REQ-006 ddr_wr_addr out ddr_addr_width; ddr_wr_req out 1 one-cycle request; ddr_wr_length out ddr_block_size_width; ddr_wr_data out ddr_data_width; ddr_wr_valid out 1; ddr_wr_ready in 1; ddr_wr_last out 1; ddr_wr_resp in 1 one-cycle write-complete strobe.
Function
REQ-007 States IDLE, REQ, XFER, RESP, DONE; reset state IDLE.
REQ-008 start is accepted only in IDLE; start in any other state is ignored with no side effect.
REQ-009 On accepted start, buffer_id, ddr_base_addr, ddr_block_size are registered; buffer_id >3 -> DONE with error; ddr_block_size 0 -> DONE, no error, no DDR request; otherwise -> REQ.
REQ-010 REQ lasts one cycle: ddr_wr_req=1, ddr_wr_addr=registered base, ddr_wr_length=registered size; then XFER.
REQ-011 Outside REQ, ddr_wr_req=0 and ddr_wr_addr/ddr_wr_length=0.
REQ-012 In XFER, a buffer read issues (selected one-hot rd_en=1, buffer_addr=issue count) when issued<size and skid occupancy plus reads in flight <2.
REQ-013 Buffer addresses start at 0 and increment by 1 per issued read; only the selected buffer's rd_en ever asserts.
REQ-014 Returned buffer_rd_data enters a 2-entry skid FIFO; FIFO head drives ddr_wr_data, ddr_wr_valid=FIFO non-empty.
REQ-015 A beat transfers when ddr_wr_valid and ddr_wr_ready are high; ddr_wr_data and ddr_wr_last hold stable while valid and not ready.
REQ-016 ddr_wr_last=1 exactly on beat index size-1; after that beat transfers -> RESP.
REQ-017 Simultaneous FIFO push and pop in one cycle keeps occupancy unchanged; no overflow or underflow is possible.
REQ-018 Throughput: with ddr_wr_ready held 1, one beat per cycle; first ddr_wr_valid 2 cycles after REQ.
REQ-019 RESP waits for ddr_wr_resp; ddr_wr_resp arriving in the last-beat cycle or earlier is latched and honored.
REQ-020 DONE lasts one cycle, then IDLE; done pulses in the cycle after DONE; error pulses alongside done when set.
REQ-021 Counters are ddr_block_size_width bits; size 255 is the maximum; no wrap is possible within a command.
REQ-022 Buffer read latency is fixed at 1 cycle; no read is issued outside XFER.
Reset
REQ-023 n_reset low asynchronously forces state IDLE, counters 0, FIFO empty, and all outputs 0.
REQ-024 Reset mid-transfer abandons the command; no done pulse is produced; the next start after reset release is a fresh command.
REQ-025 Reset release is synchronized before use internally; first start is accepted 2 cycles after deassertion.
Structure
REQ-026 The buffer-id constants (INST 0, BIAS 1, TAIL 2, RANK 3) and the state encoding belong in a shared package also used by the DDR loader.
REQ-027 The 2-entry skid FIFO is one sub-module, skid_fifo2, parameterized by data width; the rest is flat.
REQ-028 Total RTL is 150-300 lines.
Verification
REQ-029 id=1, base 0x1000, size 4, ready=1 -> req with addr 0x1000 length 4; bias_rd_en on addr 0..3; 4 beats back-to-back, last on beat 3; resp -> done 1 pulse.
REQ-030 id=0, size 8, ready toggled 1,0,0,1,... -> every word delivered in order exactly once, data stable while stalled, no read issued with FIFO full.
REQ-031 size 0 -> no ddr_wr_req, no rd_en, done pulse within 3 cycles, error 0.
REQ-032 id=5, size 4 -> no DDR or buffer activity; done and error pulse together.
REQ-033 start pulsed again during XFER -> ignored; resp arriving same cycle as last beat -> done still pulses once.
REQ-034 n_reset asserted at beat 2 of 6 -> outputs 0 immediately, no done; new id=3 size 1 command completes normally with rank_rd_en only.

Source files
------------

// File: rtl/controller_writeback_pkg.sv
// Shared definitions for the buffer-to-DDR writeback path and the DDR loader.
package controller_writeback_pkg;

    // Source buffer identifiers as seen on buffer_id
    localparam int unsigned BufInst = 0;
    localparam int unsigned BufBias = 1;
    localparam int unsigned BufTail = 2;
    localparam int unsigned BufRank = 3;
    localparam int unsigned NumBufs = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StXfer,
        StResp,
        StDone
    } wb_state_e;

    // Map a valid buffer id onto its one-hot read-enable pattern
    function automatic logic [NumBufs-1:0] buf_onehot(input logic [1:0] id);
        logic [NumBufs-1:0] oh;
        oh = '0;
        case (id)
            2'(BufInst): oh = 4'b0001;
            2'(BufBias): oh = 4'b0010;
            2'(BufTail): oh = 4'b0100;
            2'(BufRank): oh = 4'b1000;
            default:     oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO. When empty, an incoming word is presented on the output in the
// same cycle and only stored if the consumer is not ready, so a steady stream passes at
// one word per cycle with zero added latency.
module skid_fifo2 #(
    parameter int unsigned data_width = 512
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  i_in_valid,
    input  logic [data_width-1:0] i_in_data,
    output logic                  o_out_valid,
    output logic [data_width-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic [1:0]            o_count
);

    logic [data_width-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty     = (r_count == 2'd0);
    assign w_pop       = !w_empty && i_out_ready;
    // An incoming word bypasses storage only when it is consumed immediately
    assign w_push      = i_in_valid && !(w_empty && i_out_ready);
    assign o_out_valid = i_in_valid || !w_empty;
    assign o_out_data  = !w_empty ? r_mem[r_rd_ptr] : (i_in_valid ? i_in_data : '0);
    assign o_count     = r_count;

    // Storage, pointers and occupancy; push and pop together leave occupancy unchanged
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/controller_writeback.sv
// Streams a block of words from one of four on-chip buffers into a DDR write burst:
// one request, size beats with last on the final one, then waits for the write response.
module controller_writeback
    import controller_writeback_pkg::*;
#(
    parameter int unsigned ddr_addr_width       = 32,
    parameter int unsigned buffer_addr_width    = 16,
    parameter int unsigned ddr_data_width       = 512,
    parameter int unsigned ddr_block_size_width = 8,
    parameter int unsigned buffer_id_width      = 3
) (
    input  logic                            clk,
    input  logic                            n_reset,
    input  logic                            start,
    output logic                            done,
    output logic                            error,
    input  logic [buffer_id_width-1:0]      buffer_id,
    input  logic [ddr_addr_width-1:0]       ddr_base_addr,
    input  logic [ddr_block_size_width-1:0] ddr_block_size,
    output logic [buffer_addr_width-1:0]    buffer_addr,
    output logic                            buffer_inst_rd_en,
    output logic                            buffer_bias_rd_en,
    output logic                            buffer_tail_rd_en,
    output logic                            buffer_rank_rd_en,
    input  logic [ddr_data_width-1:0]       buffer_rd_data,
    output logic [ddr_addr_width-1:0]       ddr_wr_addr,
    output logic                            ddr_wr_req,
    output logic [ddr_block_size_width-1:0] ddr_wr_length,
    output logic [ddr_data_width-1:0]       ddr_wr_data,
    output logic                            ddr_wr_valid,
    input  logic                            ddr_wr_ready,
    output logic                            ddr_wr_last,
    input  logic                            ddr_wr_resp
);

    localparam logic [ddr_block_size_width-1:0] SizeOne = 1;

    logic [1:0]                      r_rst_sync;
    wb_state_e                       r_state;
    logic [NumBufs-1:0]              r_sel;
    logic [ddr_block_size_width-1:0] r_size;
    logic [ddr_block_size_width-1:0] r_issue_cnt;
    logic [ddr_block_size_width-1:0] r_beat_cnt;
    logic                            r_rd_pend;
    logic                            r_resp_seen;
    logic                            r_err;
    logic                            r_done;
    logic                            r_error;
    logic                            r_wr_req;
    logic [ddr_addr_width-1:0]       r_wr_addr;
    logic [ddr_block_size_width-1:0] r_wr_len;

    logic                            w_id_bad;
    logic                            w_issue;
    logic                            w_beat;
    logic                            w_last;
    logic                            w_fifo_valid;
    logic [ddr_data_width-1:0]       w_fifo_data;
    logic [1:0]                      w_fifo_count;
    logic [1:0]                      w_in_flight;
    logic [NumBufs-1:0]              w_rd_en;

    assign w_id_bad    = (buffer_id > buffer_id_width'(BufRank));
    // Words held or returning; a new read only goes out if it is guaranteed a FIFO slot
    assign w_in_flight = w_fifo_count + {1'b0, r_rd_pend};
    assign w_issue     = (r_state == StXfer) && (r_issue_cnt < r_size) && (w_in_flight < 2'd2);
    assign w_rd_en     = w_issue ? r_sel : '0;
    assign w_beat      = w_fifo_valid && ddr_wr_ready;
    assign w_last      = w_fifo_valid && (r_beat_cnt == r_size - SizeOne);

    assign {buffer_rank_rd_en, buffer_tail_rd_en, buffer_bias_rd_en, buffer_inst_rd_en} = w_rd_en;
    assign buffer_addr   = w_issue ? buffer_addr_width'(r_issue_cnt) : '0;
    assign ddr_wr_req    = r_wr_req;
    assign ddr_wr_addr   = r_wr_addr;
    assign ddr_wr_length = r_wr_len;
    assign ddr_wr_valid  = w_fifo_valid;
    assign ddr_wr_data   = w_fifo_data;
    assign ddr_wr_last   = w_last;
    assign done          = r_done;
    assign error         = r_error;

    skid_fifo2 #(
        .data_width (ddr_data_width)
    ) u_skid (
        .clk         (clk),
        .n_reset     (n_reset),
        .i_in_valid  (r_rd_pend),
        .i_in_data   (buffer_rd_data),
        .o_out_valid (w_fifo_valid),
        .o_out_data  (w_fifo_data),
        .i_out_ready (ddr_wr_ready),
        .o_count     (w_fifo_count)
    );

    // Reset release synchroniser; commands are refused until it has filled
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Command FSM with its counters and registered DDR request / completion outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= StIdle;
            r_sel       <= '0;
            r_size      <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_resp_seen <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_len    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_rd_pend <= w_issue;
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + SizeOne;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + SizeOne;
            end
            // A response that beats the last data beat must not be lost
            if (ddr_wr_resp && (r_state == StReq || r_state == StXfer)) begin
                r_resp_seen <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (start && r_rst_sync[1]) begin
                        r_sel       <= buf_onehot(buffer_id[1:0]);
                        r_size      <= ddr_block_size;
                        r_issue_cnt <= '0;
                        r_beat_cnt  <= '0;
                        r_resp_seen <= 1'b0;
                        r_err       <= w_id_bad;
                        if (w_id_bad || ddr_block_size == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= ddr_base_addr;
                            r_wr_len  <= ddr_block_size;
                            r_state   <= StReq;
                        end
                    end
                end
                StReq: begin
                    r_wr_req  <= 1'b0;
                    r_wr_addr <= '0;
                    r_wr_len  <= '0;
                    r_state   <= StXfer;
                end
                StXfer: begin
                    if (w_beat && w_last) begin
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    if (r_resp_seen || ddr_wr_resp) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_error <= r_err;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
